// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared pipeline definitions for the RV32I core: the ALU
//                operation encodings, the writeback-select encodings, the
//                packed decode control bundle and its bubble (all-zero) value.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  // ALU operation encodings (ADD is zero so a bubble decodes to ADD)
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;
  localparam logic [3:0] ALU_LUI  = 4'b1111;

  // Writeback result select
  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef struct packed {
    logic       RegWrite;
    logic       MemWrite;
    logic       ALUSrc;
    logic       branch;
    logic       jump;
    logic       jalr;
    logic [3:0] ALUControl;
    logic [1:0] ResultSrc;
    logic [2:0] AddressingControl;
  } ctrl_t;

  // A bubble carries no side effects: no write, no store, no control transfer
  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Up-counter that sticks at all-ones instead of wrapping.
//                Asynchronous active-high reset clears it.
//  Ports       : clk   - rising-edge clock
//                rst   - asynchronous active-high reset
//                inc   - count one event on this edge
//                count - current count value
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (inc && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/id_ex_reg.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_reg
//  Description : Decode-to-execute pipeline register. Captures the decode
//                control bundle, operands, immediates and register indices.
//                Edge priority: rst > flushE (bubble) > stallE (hold) > load.
//  Ports       : clk, rst (async, active-high), stallE, flushE, validD,
//                *D decode-stage inputs, *E registered execute-stage outputs,
//                bubbleCountE / stallCountE hazard activity counters.
//  Config      : ID_EX_PERF_EN - when defined, builds two saturating hazard
//                counters; otherwise the counter outputs are tied to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module id_ex_reg #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stallE,
  input  logic                      flushE,
  input  logic                      validD,
  input  logic                      RegWriteD,
  input  logic                      MemWriteD,
  input  logic                      ALUSrcD,
  input  logic                      branchD,
  input  logic                      jumpD,
  input  logic                      jalrD,
  input  logic [3:0]                ALUControlD,
  input  logic [1:0]                ResultSrcD,
  input  logic [2:0]                AddressingControlD,
  input  logic [DATA_WIDTH-1:0]     RD1D,
  input  logic [DATA_WIDTH-1:0]     RD2D,
  input  logic [DATA_WIDTH-1:0]     PCD,
  input  logic [DATA_WIDTH-1:0]     ImmExtD,
  input  logic [DATA_WIDTH-1:0]     PCPlus4D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
  input  logic [REG_ADDR_WIDTH-1:0] RdD,
  output logic                      validE,
  output logic                      RegWriteE,
  output logic                      MemWriteE,
  output logic                      ALUSrcE,
  output logic                      branchE,
  output logic                      jumpE,
  output logic                      jalrE,
  output logic [3:0]                ALUControlE,
  output logic [1:0]                ResultSrcE,
  output logic [2:0]                AddressingControlE,
  output logic [DATA_WIDTH-1:0]     RD1E,
  output logic [DATA_WIDTH-1:0]     RD2E,
  output logic [DATA_WIDTH-1:0]     PCE,
  output logic [DATA_WIDTH-1:0]     ImmExtE,
  output logic [DATA_WIDTH-1:0]     PCPlus4E,
  output logic [REG_ADDR_WIDTH-1:0] Rs1E,
  output logic [REG_ADDR_WIDTH-1:0] Rs2E,
  output logic [REG_ADDR_WIDTH-1:0] RdE,
  output logic [31:0]               bubbleCountE,
  output logic [31:0]               stallCountE
);

  import pipe_pkg::*;

  ctrl_t                     w_ctrl_d;
  ctrl_t                     r_ctrl;
  logic                      r_valid;
  logic [DATA_WIDTH-1:0]     r_rd1;
  logic [DATA_WIDTH-1:0]     r_rd2;
  logic [DATA_WIDTH-1:0]     r_pc;
  logic [DATA_WIDTH-1:0]     r_imm;
  logic [DATA_WIDTH-1:0]     r_pc4;
  logic [REG_ADDR_WIDTH-1:0] r_rs1;
  logic [REG_ADDR_WIDTH-1:0] r_rs2;
  logic [REG_ADDR_WIDTH-1:0] r_rd;

  always_comb begin
    w_ctrl_d                   = CTRL_BUBBLE;
    w_ctrl_d.RegWrite          = RegWriteD;
    w_ctrl_d.MemWrite          = MemWriteD;
    w_ctrl_d.ALUSrc            = ALUSrcD;
    w_ctrl_d.branch            = branchD;
    w_ctrl_d.jump              = jumpD;
    w_ctrl_d.jalr              = jalrD;
    w_ctrl_d.ALUControl        = ALUControlD;
    w_ctrl_d.ResultSrc         = ResultSrcD;
    w_ctrl_d.AddressingControl = AddressingControlD;
  end

  // Reset and flush load the same bubble: data and indices are zeroed too,
  // so RdE=x0 can never match a forwarding comparison.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ctrl  <= CTRL_BUBBLE;
      r_valid <= 1'b0;
      r_rd1   <= '0;
      r_rd2   <= '0;
      r_pc    <= '0;
      r_imm   <= '0;
      r_pc4   <= '0;
      r_rs1   <= '0;
      r_rs2   <= '0;
      r_rd    <= '0;
    end else if (flushE) begin
      r_ctrl  <= CTRL_BUBBLE;
      r_valid <= 1'b0;
      r_rd1   <= '0;
      r_rd2   <= '0;
      r_pc    <= '0;
      r_imm   <= '0;
      r_pc4   <= '0;
      r_rs1   <= '0;
      r_rs2   <= '0;
      r_rd    <= '0;
    end else if (!stallE) begin
      // Control is captured unmasked even when validD=0; upstream owns that.
      r_ctrl  <= w_ctrl_d;
      r_valid <= validD;
      r_rd1   <= RD1D;
      r_rd2   <= RD2D;
      r_pc    <= PCD;
      r_imm   <= ImmExtD;
      r_pc4   <= PCPlus4D;
      r_rs1   <= Rs1D;
      r_rs2   <= Rs2D;
      r_rd    <= RdD;
    end
  end

  assign validE             = r_valid;
  assign RegWriteE          = r_ctrl.RegWrite;
  assign MemWriteE          = r_ctrl.MemWrite;
  assign ALUSrcE            = r_ctrl.ALUSrc;
  assign branchE            = r_ctrl.branch;
  assign jumpE              = r_ctrl.jump;
  assign jalrE              = r_ctrl.jalr;
  assign ALUControlE        = r_ctrl.ALUControl;
  assign ResultSrcE         = r_ctrl.ResultSrc;
  assign AddressingControlE = r_ctrl.AddressingControl;
  assign RD1E               = r_rd1;
  assign RD2E               = r_rd2;
  assign PCE                = r_pc;
  assign ImmExtE            = r_imm;
  assign PCPlus4E           = r_pc4;
  assign Rs1E               = r_rs1;
  assign Rs2E               = r_rs2;
  assign RdE                = r_rd;

`ifdef ID_EX_PERF_EN
  logic w_bubble_inc;
  logic w_stall_inc;

  // A cycle with both stall and flush counts as a bubble only.
  assign w_bubble_inc = flushE;
  assign w_stall_inc  = stallE & ~flushE;

  sat_counter #(.WIDTH(32)) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_bubble_inc),
    .count (bubbleCountE)
  );

  sat_counter #(.WIDTH(32)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_stall_inc),
    .count (stallCountE)
  );
`else
  assign bubbleCountE = '0;
  assign stallCountE  = '0;
`endif

endmodule : id_ex_reg
`default_nettype wire

// File: tb/tb_id_ex_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_ex_reg
//  Description : Scoreboard testbench for id_ex_reg. The driver pushes the
//                hand-computed expected E bundle for each issued cycle; a
//                monitor pops and compares it on the falling edge after the
//                capturing rising edge. Counter checks run when
//                ID_EX_PERF_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_reg;

  typedef struct packed {
    logic        RegWrite;
    logic        MemWrite;
    logic        ALUSrc;
    logic        branch;
    logic        jump;
    logic        jalr;
    logic [3:0]  ALUControl;
    logic [1:0]  ResultSrc;
    logic [2:0]  AddrCtl;
    logic [31:0] RD1;
    logic [31:0] RD2;
    logic [31:0] PC;
    logic [31:0] Imm;
    logic [31:0] PCPlus4;
    logic [4:0]  Rs1;
    logic [4:0]  Rs2;
    logic [4:0]  Rd;
    logic        valid;
  } bundle_t;

  typedef struct {
    int      due;
    bundle_t b;
  } sb_t;

  localparam bundle_t V_ZERO = '0;
  localparam bundle_t V_ADDI = '{RegWrite:1'b1, MemWrite:1'b0, ALUSrc:1'b1, branch:1'b0,
    jump:1'b0, jalr:1'b0, ALUControl:4'b0000, ResultSrc:2'b00, AddrCtl:3'b000,
    RD1:32'h0000_0010, RD2:32'h0, PC:32'h0000_0100, Imm:32'h0000_0005,
    PCPlus4:32'h0000_0104, Rs1:5'd2, Rs2:5'd0, Rd:5'd3, valid:1'b1};
  localparam bundle_t V_SW   = '{RegWrite:1'b0, MemWrite:1'b1, ALUSrc:1'b1, branch:1'b0,
    jump:1'b0, jalr:1'b0, ALUControl:4'b0000, ResultSrc:2'b00, AddrCtl:3'b010,
    RD1:32'h0000_2000, RD2:32'hDEAD_BEEF, PC:32'h0000_0104, Imm:32'h0000_0008,
    PCPlus4:32'h0000_0108, Rs1:5'd4, Rs2:5'd5, Rd:5'd0, valid:1'b1};
  localparam bundle_t V_SUB  = '{RegWrite:1'b1, MemWrite:1'b0, ALUSrc:1'b0, branch:1'b0,
    jump:1'b0, jalr:1'b0, ALUControl:4'b0001, ResultSrc:2'b00, AddrCtl:3'b000,
    RD1:32'h0000_0007, RD2:32'h0000_0003, PC:32'h0000_0108, Imm:32'h0,
    PCPlus4:32'h0000_010C, Rs1:5'd6, Rs2:5'd7, Rd:5'd8, valid:1'b1};
  localparam bundle_t V_JAL  = '{RegWrite:1'b1, MemWrite:1'b0, ALUSrc:1'b0, branch:1'b0,
    jump:1'b1, jalr:1'b0, ALUControl:4'b0000, ResultSrc:2'b10, AddrCtl:3'b000,
    RD1:32'h0, RD2:32'h0, PC:32'h0000_010C, Imm:32'h0000_0040,
    PCPlus4:32'h0000_0110, Rs1:5'd0, Rs2:5'd0, Rd:5'd1, valid:1'b1};
  // Invalid slot with a branch-like control pattern still presented
  localparam bundle_t V_INV  = '{RegWrite:1'b0, MemWrite:1'b0, ALUSrc:1'b0, branch:1'b1,
    jump:1'b0, jalr:1'b0, ALUControl:4'b0001, ResultSrc:2'b00, AddrCtl:3'b000,
    RD1:32'h0000_0AAA, RD2:32'h0000_0555, PC:32'h0000_0200, Imm:32'hFFFF_FFF0,
    PCPlus4:32'h0000_0204, Rs1:5'd9, Rs2:5'd10, Rd:5'd0, valid:1'b0};

  logic        clk = 1'b0;
  logic        rst;
  logic        stallE;
  logic        flushE;
  bundle_t     din;
  bundle_t     dout;

  logic        validD, RegWriteD, MemWriteD, ALUSrcD, branchD, jumpD, jalrD;
  logic [3:0]  ALUControlD;
  logic [1:0]  ResultSrcD;
  logic [2:0]  AddressingControlD;
  logic [31:0] RD1D, RD2D, PCD, ImmExtD, PCPlus4D;
  logic [4:0]  Rs1D, Rs2D, RdD;
  logic        validE, RegWriteE, MemWriteE, ALUSrcE, branchE, jumpE, jalrE;
  logic [3:0]  ALUControlE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  AddressingControlE;
  logic [31:0] RD1E, RD2E, PCE, ImmExtE, PCPlus4E;
  logic [4:0]  Rs1E, Rs2E, RdE;
  logic [31:0] bubbleCountE, stallCountE;

  assign {RegWriteD, MemWriteD, ALUSrcD, branchD, jumpD, jalrD, ALUControlD, ResultSrcD,
          AddressingControlD, RD1D, RD2D, PCD, ImmExtD, PCPlus4D, Rs1D, Rs2D, RdD,
          validD} = din;
  assign dout = {RegWriteE, MemWriteE, ALUSrcE, branchE, jumpE, jalrE, ALUControlE,
                 ResultSrcE, AddressingControlE, RD1E, RD2E, PCE, ImmExtE, PCPlus4E,
                 Rs1E, Rs2E, RdE, validE};

  id_ex_reg #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) u_dut (
    .clk(clk), .rst(rst), .stallE(stallE), .flushE(flushE), .validD(validD),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .ALUSrcD(ALUSrcD),
    .branchD(branchD), .jumpD(jumpD), .jalrD(jalrD), .ALUControlD(ALUControlD),
    .ResultSrcD(ResultSrcD), .AddressingControlD(AddressingControlD),
    .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD), .ImmExtD(ImmExtD), .PCPlus4D(PCPlus4D),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .validE(validE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ALUSrcE(ALUSrcE),
    .branchE(branchE), .jumpE(jumpE), .jalrE(jalrE), .ALUControlE(ALUControlE),
    .ResultSrcE(ResultSrcE), .AddressingControlE(AddressingControlE),
    .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .ImmExtE(ImmExtE), .PCPlus4E(PCPlus4E),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .bubbleCountE(bubbleCountE), .stallCountE(stallCountE)
  );

  always #5 clk = ~clk;

  int  cyc = 0;
  int  n_tests = 0;
  int  n_fail = 0;
  sb_t sb_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_b(input string name, input bundle_t act, input bundle_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: E outputs are valid on the falling edge after the capture edge.
  always @(negedge clk) begin
    if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
      sb_t e;
      e = sb_q.pop_front();
      chk_b($sformatf("sb_cyc%0d", e.due), dout, e.b);
    end
  end

  // Drive one cycle of stimulus and queue the bundle expected after the edge.
  task automatic issue(input bundle_t d, input logic st, input logic fl, input bundle_t exp);
    sb_t e;
    din    = d;
    stallE = st;
    flushE = fl;
    e.due  = cyc + 1;
    e.b    = exp;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst    = 1'b1;
    stallE = 1'b0;
    flushE = 1'b0;
    din    = V_ZERO;
    #2;
    chk_b("reset_state", dout, V_ZERO);
    chk32("reset_bubble_cnt", bubbleCountE, 32'h0);
    chk32("reset_stall_cnt", stallCountE, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    issue(V_ADDI, 1'b0, 1'b0, V_ADDI);            // reset then load
    issue(V_SW,   1'b0, 1'b0, V_SW);
    issue(V_SUB,  1'b1, 1'b0, V_SW);              // stall x3 holds the SW
    issue(V_SUB,  1'b1, 1'b0, V_SW);
    issue(V_SUB,  1'b1, 1'b0, V_SW);
    issue(V_SUB,  1'b0, 1'b0, V_SUB);             // released
    issue(V_JAL,  1'b0, 1'b1, V_ZERO);            // flush
    issue(V_JAL,  1'b1, 1'b0, V_ZERO);            // stall holds the bubble
`ifdef ID_EX_PERF_EN
    chk32("cnt_bubble_before_both", bubbleCountE, 32'd1);
    chk32("cnt_stall_before_both", stallCountE, 32'd4);
`endif
    issue(V_JAL,  1'b1, 1'b1, V_ZERO);            // flush wins over stall
`ifdef ID_EX_PERF_EN
    chk32("cnt_bubble_after_both", bubbleCountE, 32'd2);
    chk32("cnt_stall_after_both", stallCountE, 32'd4);
`endif
    issue(V_INV,  1'b0, 1'b0, V_INV);             // validD=0 captured unmasked
    issue(V_ADDI, 1'b0, 1'b0, V_ADDI);

    // Asynchronous reset between edges while validE=1
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk_b("async_reset_outputs", dout, V_ZERO);
    chk32("async_reset_bubble_cnt", bubbleCountE, 32'h0);
    chk32("async_reset_stall_cnt", stallCountE, 32'h0);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    issue(V_SW, 1'b0, 1'b0, V_SW);                // recovery after reset

`ifdef ID_EX_PERF_EN
    force u_dut.u_bubble_cnt.r_count = 32'hFFFF_FFFE;
    #1;
    release u_dut.u_bubble_cnt.r_count;
    issue(V_SUB, 1'b0, 1'b1, V_ZERO);
    chk32("sat_first", bubbleCountE, 32'hFFFF_FFFF);
    issue(V_SUB, 1'b0, 1'b1, V_ZERO);
    chk32("sat_hold1", bubbleCountE, 32'hFFFF_FFFF);
    issue(V_SUB, 1'b0, 1'b1, V_ZERO);
    chk32("sat_hold2", bubbleCountE, 32'hFFFF_FFFF);
    chk32("sat_stall_cnt", stallCountE, 32'h0);
`endif

    issue(V_JAL, 1'b0, 1'b0, V_JAL);
    stallE = 1'b0;
    flushE = 1'b0;
    @(negedge clk);
    #1;
    chk32("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_id_ex_reg
`default_nettype wire

// File: doc/id_ex_reg.md
# id_ex_reg

Decode-to-execute pipeline register for the pipelined RV32I core. It captures the control bundle from the decode-stage control unit together with the decoded operands, immediates and register indices, and presents them to the execute stage one cycle later. It supports hold (stall), bubble insertion (flush) and a valid bit. An optional pair of saturating counters reports hazard activity.

## Interface
Parameters:
- DATA_WIDTH, 32, width of the operand, PC and immediate fields
- REG_ADDR_WIDTH, 5, width of the register index fields

Ports (clock and reset: one clock; reset is asynchronous and active-high):
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- stallE  in  1  hold the current contents
- flushE  in  1  load a bubble
- validD  in  1  a real instruction is in decode
- RegWriteD, MemWriteD, ALUSrcD, branchD, jumpD, jalrD  in  1 each  control bundle from decode
- ALUControlD  in  4  ALU operation
- ResultSrcD  in  2  writeback select
- AddressingControlD  in  3  load/store size and sign (funct3)
- RD1D, RD2D, PCD, ImmExtD, PCPlus4D  in  DATA_WIDTH each  operands and addresses
- Rs1D, Rs2D, RdD  in  REG_ADDR_WIDTH each  register indices (forwarding and hazard use)
- All of the above with suffix E  out  same widths  registered copies; validE  out  1
- bubbleCountE, stallCountE  out  32 each  hazard counters (see Configuration)

## Operation
- Update priority per rising edge: rst > flushE > stallE > load.
- Load: every E output takes its D input. validE takes validD.
- Stall (stallE=1, flushE=0): all E outputs and validE hold.
- Flush (flushE=1): the register takes a bubble. validE=0, all control outputs=0 (ALUControlE=ADD 4'b0000, ResultSrcE=00, AddressingControlE=000), and all data and index outputs=0. RdE=0, so no write and no forwarding match against x0.
- flushE and stallE asserted together: flush wins, and the cycle counts as a bubble only.
- A bubble must never assert RegWriteE, MemWriteE, branchE, jumpE or jalrE.
- validD=0 with a load: fields are captured as presented, and validE=0. Control is not masked by the block; the upstream stage is responsible for that.
- Stall while validE=0: the bubble holds.

## Timing
- Latency: exactly 1 cycle from D inputs to E outputs on a load.
- Reset: asynchronous assert. All outputs go to 0 immediately, including validE and both counters. Deassertion is taken synchronously at the next edge.
- Reset mid-stall or mid-flush: reset wins, and the stall or flush is lost.
- No combinational path from any input to any output.

## Configuration
- Macro: ID_EX_PERF_EN.
- Defined:
  - bubbleCountE increments on each edge with flushE=1.
  - stallCountE increments on each edge with stallE=1 and flushE=0.
  - Both saturate at 32'hFFFF_FFFF and never wrap.
  - Both clear on rst.
- Undefined: both counter ports are tied to 0 and no counter flops are built. Pipeline behaviour is identical in both builds.

## Structure
- Shared package pipe_pkg holds:
  - the ALU encoding constants (ADD 0000, SUB 0001, … LUI 1111)
  - the ResultSrc encodings (00 ALU, 01 memory, 10 PC+4)
  - the packed control struct ctrl_t (RegWrite, MemWrite, ALUSrc, branch, jump, jalr, ALUControl, ResultSrc, AddressingControl)
  - the constant CTRL_BUBBLE (all zero)
- One sub-module, sat_counter (parameter WIDTH, ports: clk, rst, inc, count), instantiated twice under ID_EX_PERF_EN.

## Test plan
- Reset then load: reset, then load an ADDI (RegWriteD=1, ALUSrcD=1, ALUControlD=0000, ImmExtD=5, RdD=3, validD=1). The next cycle shows RegWriteE=1, ImmExtE=5, RdE=3, validE=1.
- Stall: load a SW (MemWriteD=1, AddressingControlD=010), then hold stallE=1 for 3 cycles while the D inputs change to an R-type SUB. The E outputs keep MemWriteE=1 and AddressingControlE=010 throughout.
- Flush: with a JAL in decode (jumpD=1, ResultSrcD=10, RdD=1), assert flushE. The next cycle shows jumpE=0, RegWriteE=0, RdE=0, validE=0.
- Simultaneous stall and flush: assert both for one cycle. A bubble is loaded. With ID_EX_PERF_EN, bubbleCountE increments by 1 and stallCountE is unchanged.
- Async reset mid-operation: assert rst between edges while validE=1. All outputs are 0 before the next edge, and the counters clear.
- Saturation (ID_EX_PERF_EN): force bubbleCountE to 32'hFFFF_FFFE, then flush for 3 cycles. The count reads FFFF_FFFF and stays there.
